mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU, and supports MTHI/MTLO writes.
- Sits beside the EX-stage ALU.
- The hazard logic stalls the pipeline while busy_o is high; MFHI/MFLO read hi_o/lo_o directly.

Parameters:
DATA_WIDTH, 32, operand width W; W >= 4; HI and LO are each W bits.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
start_i  input  1  launch operation; sampled only in IDLE
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
a_i  input  W  operand rs (multiplicand / dividend); also MTHI/MTLO data
b_i  input  W  operand rt (multiplier / divisor)
hi_we_i  input  1  MTHI: HI <= a_i
lo_we_i  input  1  MTLO: LO <= a_i
flush_i  input  1  abort operation in progress
busy_o  output  1  high when state != IDLE
done_o  output  1  one-cycle registered pulse; result valid in HI/LO
div_by_zero_o  output  1  registered; pulses with done_o when a DIV/DIVU had b_i == 0
hi_o  output  W  HI register
lo_o  output  W  LO register

Behaviour:
- Reset values: state IDLE; hi_o = 0, lo_o = 0, done_o = 0, div_by_zero_o = 0, iteration counter = 0.
- States and transitions:
  - IDLE -> CALC on start_i.
  - CALC -> FIX after the W-th iteration.
  - FIX -> IDLE unconditionally.
- Start edge (IDLE, start_i = 1):
  - Latch op, sign flags and operand magnitudes.
  - Signed ops take the two's-complement absolute value. The most-negative value is kept as unsigned 2^(W-1).
  - Record the divide-by-zero flag.
  - Counter <= 0.
- CALC:
  - One bit per cycle.
  - Multiply: shift-add into a 2W-bit accumulator.
  - Divide: restoring division, W-bit quotient and remainder.
  - Counter increments each iteration; when counter == W-1, go to FIX on that edge.
- FIX edge:
  - Apply sign correction and write HI/LO.
  - Assert done_o for exactly one cycle; state returns to IDLE.
- Latency: from the start sampling edge to done_o/HI/LO visible is W+1 cycles (33 for W=32). busy_o is high for exactly W+1 cycles.
- Sign rules, signed ops only:
  - Product: negate the 2W-bit result if the operand signs differ. HI = upper W bits, LO = lower W bits.
  - Quotient (LO): negative if the signs differ.
  - Remainder (HI): takes the dividend's sign.
  - Most-negative / -1 gives LO = most-negative, HI = 0 (wrap, no trap).
- Divide by zero:
  - Same latency.
  - HI = a_i as latched, LO = all ones; no sign correction.
  - div_by_zero_o pulses with done_o.
- start_i while busy: ignored.
- hi_we_i/lo_we_i:
  - Honoured only in IDLE.
  - If start_i is also high in that cycle, start wins and the write is dropped.
  - Both write enables may be high together.
- flush_i:
  - In CALC or FIX: state -> IDLE on the next edge. HI/LO unchanged, no done_o.
  - In IDLE: blocks a same-cycle start.
- Reset has priority over everything, including mid-operation: full clear, no done_o.

Decomposition:
- Shared package:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encodings: IDLE, CALC, FIX.
  - Counter width: clog2(W+1).
- One natural sub-module, mult_div_core: iteration datapath (accumulator, shift, subtract/restore, sign fix).
- The top level holds the FSM, counter, HI/LO registers and flags.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> after 33 cycles done_o=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy_o high exactly 33 cycles.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. Signed division:
   - DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
4. DIVU a=100, b=0 -> HI=0x00000064, LO=0xFFFFFFFF, div_by_zero_o=1 in the same cycle as done_o.
5. MTHI a=0x1234 then MTLO a=0x5678 in IDLE -> HI=0x1234, LO=0x5678. Then:
   - Start MULT; start_i and hi_we_i are re-asserted at cycle 5 -> ignored.
   - flush_i at cycle 10 -> busy_o low next cycle, no done_o, HI=0x1234, LO=0x5678.
6. Start DIV, assert reset at cycle 12 -> next cycle busy_o=0, HI=LO=0, done_o never pulses. A new start afterwards completes normally in 33 cycles.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared encodings and helpers for the iterative mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    // Operation encodings as presented on op_i
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Iteration counter must hold values 0..W
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Odd encodings are the unsigned variants
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_core.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_core
// Description : Iteration datapath: shift-add multiply, restoring divide,
//               operand magnitude capture and final sign correction.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_core
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_dbz
);
    localparam int W = DATA_WIDTH;

    // Accumulator: multiply = {partial product, multiplier};
    //              divide   = {remainder, dividend/quotient}
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [W-1:0]   r_a_raw;    // dividend as presented, for the /0 result
    logic           r_is_div;
    logic           r_neg_res;  // product / quotient needs negation
    logic           r_neg_rem;  // remainder follows dividend sign
    logic           r_dbz;

    logic           w_signed;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_shift;
    logic [W:0]     w_diff;
    logic           w_ge;
    logic [2*W-1:0] w_div_next;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;

    // Operand magnitudes; -2^(W-1) negates to itself, read as unsigned 2^(W-1)
    always_comb begin
        w_signed = op_is_signed(i_op);
        w_a_neg  = w_signed & i_a[W-1];
        w_b_neg  = w_signed & i_b[W-1];
        w_mag_a  = w_a_neg ? -i_a : i_a;
        w_mag_b  = w_b_neg ? -i_b : i_b;
    end

    // One multiply step (shift-add) and one restoring-divide step
    always_comb begin
        w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opnd};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};
        w_shift    = r_acc[2*W-1:W-1];
        w_diff     = w_shift - {1'b0, r_opnd};
        w_ge       = (w_shift >= {1'b0, r_opnd});
        w_div_next = w_ge ? {w_diff[W-1:0],  r_acc[W-2:0], 1'b1}
                          : {w_shift[W-1:0], r_acc[W-2:0], 1'b0};
    end

    // Sign-corrected result presented to the HI/LO registers
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quo  = r_acc[W-1:0];
        w_rem  = r_acc[2*W-1:W];
        o_dbz  = r_dbz;
        if (!r_is_div) begin
            o_hi = w_prod[2*W-1:W];
            o_lo = w_prod[W-1:0];
        end else if (r_dbz) begin
            o_hi = r_a_raw;
            o_lo = '1;
        end else begin
            o_hi = r_neg_rem ? -w_rem : w_rem;
            o_lo = r_neg_res ? -w_quo : w_quo;
        end
    end

    // Operand capture on launch, one iteration per step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_opnd    <= '0;
            r_a_raw   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (i_load) begin
            r_is_div  <= op_is_div(i_op);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dbz     <= op_is_div(i_op) & (i_b == '0);
            r_a_raw   <= i_a;
            r_opnd    <= op_is_div(i_op) ? w_mag_b : w_mag_a;
            r_acc     <= {{W{1'b0}}, (op_is_div(i_op) ? w_mag_a : w_mag_b)};
        end else if (i_step) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers,
//               MTHI/MTLO writes, flush and divide-by-zero reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  hi_we_i,
    input  logic                  lo_we_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  div_by_zero_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    localparam int CNT_W = cnt_width(DATA_WIDTH);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic                r_done;
    logic                r_dbz;

    logic                w_start;
    logic                w_step;
    logic                w_commit;
    logic                w_last;
    logic [DATA_WIDTH-1:0] w_core_hi;
    logic [DATA_WIDTH-1:0] w_core_lo;
    logic                w_core_dbz;

    mult_div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_start),
        .i_step (w_step),
        .i_op   (op_i),
        .i_a    (a_i),
        .i_b    (b_i),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo),
        .o_dbz  (w_core_dbz)
    );

    // Next state and per-state control strobes
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        w_last   = (r_cnt == CNT_W'(DATA_WIDTH - 1));
        case (r_state)
            IDLE: begin
                w_start = start_i & ~flush_i;
                if (w_start) w_next = CALC;
            end
            CALC: begin
                w_step = ~flush_i;
                if (flush_i)     w_next = IDLE;
                else if (w_last) w_next = FIX;
            end
            FIX: begin
                w_commit = ~flush_i;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Iteration counter, restarted on every launch
    always_ff @(posedge clk) begin
        if (reset)       r_cnt <= '0;
        else if (w_start) r_cnt <= '0;
        else if (w_step)  r_cnt <= r_cnt + CNT_W'(1);
    end

    // HI/LO: result commit, or MTHI/MTLO when idle and not launching
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_core_hi;
            r_lo <= w_core_lo;
        end else if (r_state == IDLE && !start_i) begin
            if (hi_we_i) r_hi <= a_i;
            if (lo_we_i) r_lo <= a_i;
        end
    end

    // Completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_dbz  <= w_commit & w_core_dbz;
        end
    end

    assign busy_o        = (r_state != IDLE);
    assign done_o        = r_done;
    assign div_by_zero_o = r_dbz;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit with a transaction-level
//               reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    op_i = 2'b00;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          hi_we_i = 1'b0;
    logic          lo_we_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          div_by_zero_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .hi_we_i       (hi_we_i),
        .lo_we_i       (lo_we_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of each operation, straight from the ISA rules
    task automatic predict(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        logic [63:0] p;
        longint      q;
        longint      r;
        dbz = 1'b0;
        if (!op[1]) begin
            if (!op[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else        p = 64'(a) * 64'(b);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == '0) begin
            hi  = a;
            lo  = '1;
            dbz = 1'b1;
        end else if (!op[0]) begin
            q  = longint'($signed(a)) / longint'($signed(b));
            r  = longint'($signed(a)) % longint'($signed(b));
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Reference model: HI/LO, a busy countdown and pending result
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic         m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
    int           m_left = 0;

    always @(posedge clk) begin
        m_done = 1'b0;
        m_dbz  = 1'b0;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left == 0) begin
            if (start_i && !flush_i) begin
                predict(op_i, a_i, b_i, p_hi, p_lo, p_dbz);
                m_left = LAT;
            end else if (!start_i) begin
                if (hi_we_i) m_hi = a_i;
                if (lo_we_i) m_lo = a_i;
            end
        end else if (flush_i) begin
            m_left = 0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        chk("busy",  64'(busy_o),        64'(m_left != 0));
        chk("done",  64'(done_o),        64'(m_done));
        chk("dbz",   64'(div_by_zero_o), 64'(m_dbz));
        chk("hi",    64'(hi_o),          64'(m_hi));
        chk("lo",    64'(lo_o),          64'(m_lo));
    end

    // Launch one operation and check latency, busy length and literal results
    task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_hi,
                          input logic [W-1:0] e_lo, input logic e_dbz);
        int cyc;
        int bcyc;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        cyc  = 0;
        bcyc = busy_o ? 1 : 0;
        while (!done_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy_o) bcyc++;
        end
        chk({nm, "_latency"}, 64'(cyc),  64'(LAT));
        chk({nm, "_busycyc"}, 64'(bcyc), 64'(LAT));
        chk({nm, "_hi"},      64'(hi_o), 64'(e_hi));
        chk({nm, "_lo"},      64'(lo_o), 64'(e_lo));
        chk({nm, "_dbz"},     64'(div_by_zero_o), 64'(e_dbz));
    endtask

    initial begin
        int npulse;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hi",   64'(hi_o),   64'd0);
        chk("rst_lo",   64'(lo_o),   64'd0);
        reset = 1'b0;

        run_op("mult_neg",    2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu_zero",   2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1);
        run_op("div_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("divu_big",    2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0);
        run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("mult_min_m1", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("div_zero_s",  2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

        // MTHI / MTLO in idle
        @(negedge clk); hi_we_i = 1'b1; a_i = 32'h1234;
        @(negedge clk); hi_we_i = 1'b0; lo_we_i = 1'b1; a_i = 32'h5678;
        @(negedge clk); lo_we_i = 1'b0;
        chk("mthi", 64'(hi_o), 64'h1234);
        chk("mtlo", 64'(lo_o), 64'h5678);

        // Start ignored while busy, then flush
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd5;
        @(negedge clk); start_i = 1'b0;
        repeat (4) @(negedge clk);
        start_i = 1'b1; hi_we_i = 1'b1; a_i = 32'hDEAD;
        @(negedge clk); start_i = 1'b0; hi_we_i = 1'b0;
        repeat (4) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_done", 64'(done_o), 64'd0);
        chk("flush_hi",   64'(hi_o),   64'h1234);
        chk("flush_lo",   64'(lo_o),   64'h5678);
        npulse = 0;
        repeat (40) begin @(negedge clk); if (done_o) npulse++; end
        chk("flush_nodone", 64'(npulse), 64'd0);

        // Reset mid-operation
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd1000; b_i = 32'd7;
        @(negedge clk); start_i = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_hi",   64'(hi_o),   64'd0);
        chk("midrst_lo",   64'(lo_o),   64'd0);
        npulse = 0;
        repeat (40) begin @(negedge clk); if (done_o) npulse++; end
        chk("midrst_nodone", 64'(npulse), 64'd0);
        run_op("after_rst", 2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
